// File: rtl/generate_hour.sv
// Hour counter for a digital clock: BCD hour digits in 24-hour or 12-hour (AM/PM) form,
// advanced by the minute rollover in RUN mode or by a debounced button edge in SET mode.
module generate_hour #(
    parameter int FMT24 = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hr_en,
    input  logic       key,
    input  logic       inc,
    output logic [3:0] h1,
    output logic [3:0] h2,
    output logic       pm,
    output logic       day_en
);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } mode_t;

    localparam logic [3:0] RST_H1 = (FMT24 != 0) ? 4'd0 : 4'd1;
    localparam logic [3:0] RST_H2 = (FMT24 != 0) ? 4'd0 : 4'd2;

    mode_t      mode;
    logic       inc_d;
    logic       adv_run;
    logic       adv_set;
    logic       advance;
    logic [3:0] nxt_h1;
    logic [3:0] nxt_h2;
    logic       nxt_pm;
    logic       wrap_day;

    // Returns {h1, h2, pm, day_wrap}; any illegal digit pair falls back to the reset hour.
    function automatic logic [9:0] next_hour24(input logic [3:0] t, input logic [3:0] u);
        logic [9:0] r;
        if (t > 4'd2 || u > 4'd9 || (t == 4'd2 && u > 4'd3))
            r = {4'd0, 4'd0, 1'b0, 1'b0};
        else if (t == 4'd2 && u == 4'd3)
            r = {4'd0, 4'd0, 1'b0, 1'b1};
        else if (u == 4'd9)
            r = {t + 4'd1, 4'd0, 1'b0, 1'b0};
        else
            r = {t, u + 4'd1, 1'b0, 1'b0};
        return r;
    endfunction

    // 12-hour form runs 12,01..11; the day wraps only when 11 PM becomes 12 AM.
    function automatic logic [9:0] next_hour12(input logic [3:0] t, input logic [3:0] u,
                                               input logic p);
        logic [9:0] r;
        if (t > 4'd1 || u > 4'd9 || (t == 4'd1 && u > 4'd2) || (t == 4'd0 && u == 4'd0))
            r = {4'd1, 4'd2, p, 1'b0};
        else if (t == 4'd1 && u == 4'd2)
            r = {4'd0, 4'd1, p, 1'b0};
        else if (t == 4'd1 && u == 4'd1)
            r = {4'd1, 4'd2, ~p, p};
        else if (u == 4'd9)
            r = {4'd1, 4'd0, p, 1'b0};
        else
            r = {t, u + 4'd1, p, 1'b0};
        return r;
    endfunction

    // Advance decisions use the registered mode, so a key change takes effect next cycle.
    always_comb begin
        adv_run = (mode == RUN) && hr_en;
        adv_set = (mode == SET) && inc && !inc_d;
        advance = adv_run || adv_set;
        if (FMT24 != 0)
            {nxt_h1, nxt_h2, nxt_pm, wrap_day} = next_hour24(h1, h2);
        else
            {nxt_h1, nxt_h2, nxt_pm, wrap_day} = next_hour12(h1, h2, pm);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode   <= RUN;
            inc_d  <= 1'b0;
            h1     <= RST_H1;
            h2     <= RST_H2;
            pm     <= 1'b0;
            day_en <= 1'b0;
        end else begin
            mode   <= key ? RUN : SET;
            inc_d  <= inc;
            day_en <= adv_run && wrap_day;
            if (advance) begin
                h1 <= nxt_h1;
                h2 <= nxt_h2;
                pm <= nxt_pm;
            end
        end
    end

endmodule

// File: tb/tb_generate_hour.sv
// Bench for generate_hour: a 24-hour and a 12-hour instance share stimulus and are
// compared every cycle against an hour-index model through an expectation queue.
module tb_generate_hour;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hr_en = 1'b0;
    logic       key = 1'b1;
    logic       inc = 1'b0;
    logic [3:0] a_h1, a_h2, b_h1, b_h2;
    logic       a_pm, a_day, b_pm, b_day;

    generate_hour #(.FMT24(1)) dut24 (
        .clk(clk), .reset(reset), .hr_en(hr_en), .key(key), .inc(inc),
        .h1(a_h1), .h2(a_h2), .pm(a_pm), .day_en(a_day)
    );

    generate_hour #(.FMT24(0)) dut12 (
        .clk(clk), .reset(reset), .hr_en(hr_en), .key(key), .inc(inc),
        .h1(b_h1), .h2(b_h2), .pm(b_pm), .day_en(b_day)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] a;
        logic [9:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   compared = 0;
    int   mismatched = 0;

    // Hour index 0..23 serves both formats: 0 = 00 / 12 AM, 12 = 12 / 12 PM.
    int idx = 0;
    bit m_run = 1'b1;
    bit m_inc = 1'b0;

    function automatic exp_t model_out(input int hi, input bit day);
        exp_t r;
        int   d;
        d   = (hi % 12 == 0) ? 12 : hi % 12;
        r.a = {4'(hi / 10), 4'(hi % 10), 1'b0, day};
        r.b = {4'(d / 10), 4'(d % 10), (hi >= 12) ? 1'b1 : 1'b0, day};
        return r;
    endfunction

    function automatic logic [9:0] got24();
        return {a_h1, a_h2, a_pm, a_day};
    endfunction

    function automatic logic [9:0] got12();
        return {b_h1, b_h2, b_pm, b_day};
    endfunction

    task automatic model_reset();
        idx   = 0;
        m_run = 1'b1;
        m_inc = 1'b0;
        sb.push_back(model_out(0, 1'b0));
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, settle past the edge.
    task automatic tick(input bit h, input bit k, input bit i);
        bit adv;
        bit day;
        hr_en = h;
        key   = k;
        inc   = i;
        if (reset) begin
            model_reset();
        end else begin
            adv = m_run ? h : (i && !m_inc);
            day = m_run && h && (idx == 23);
            if (adv) idx = (idx + 1) % 24;
            m_inc = i;
            m_run = k;
            sb.push_back(model_out(idx, day));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        e = sb.pop_front(); compared++;
        if (got24() !== e.a || got12() !== e.b) begin
            mismatched++;
            $display("FAIL reset_async t=%0t got24=%h got12=%h exp24=%h exp12=%h", $time, got24(), got12(), e.a, e.b);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b1, c[0]);
            e = sb.pop_front(); compared++;
            if (got24() !== e.a || got12() !== e.b) begin
                mismatched++;
                $display("FAIL reset_hold t=%0t got24=%h got12=%h exp24=%h exp12=%h", $time, got24(), got12(), e.a, e.b);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_run_24();
        for (int p = 0; p < 24; p++) begin
            for (int c = 0; c < 10; c++) begin
                tick(c == 0, 1'b1, 1'($urandom_range(0, 1)));
                e = sb.pop_front(); compared++;
                if (got24() !== e.a || got12() !== e.b) begin
                    mismatched++;
                    $display("FAIL run_24 pulse=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", p, $time, got24(), got12(), e.a, e.b);
                end
            end
        end
    endtask

    task automatic test_set_mode();
        reset = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        void'(sb.pop_front());
        for (int c = 0; c < 12; c++) begin
            tick((c >= 2) && c[0], 1'b0, 1'b0);
            e = sb.pop_front(); compared++;
            if (got24() !== e.a || got12() !== e.b) begin
                mismatched++;
                $display("FAIL set_hr_en t=%0t got24=%h got12=%h exp24=%h exp12=%h", $time, got24(), got12(), e.a, e.b);
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 12; c++) begin
                tick(c[1], 1'b0, c < 8);
                e = sb.pop_front(); compared++;
                if (got24() !== e.a || got12() !== e.b) begin
                    mismatched++;
                    $display("FAIL set_inc rep=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", r, $time, got24(), got12(), e.a, e.b);
                end
            end
        end
        if (idx != 3) begin
            mismatched++;
            $display("FAIL set_final_count got=%0d required=3", idx);
        end
        compared++;
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int c = 0; c < 30; c++) begin
            tick(1'b1, 1'b1, 1'b0);
            e = sb.pop_front(); compared++;
            if (got24() !== e.a || got12() !== e.b) begin
                mismatched++;
                $display("FAIL b2b_level c=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", c, $time, got24(), got12(), e.a, e.b);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 1'b0, c[0]);
            e = sb.pop_front(); compared++;
            if (got24() !== e.a || got12() !== e.b) begin
                mismatched++;
                $display("FAIL b2b_inc c=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", c, $time, got24(), got12(), e.a, e.b);
            end
        end
    endtask

    task automatic test_key_race();
        reset = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        void'(sb.pop_front());
        for (int c = 0; c < 23; c++) begin
            tick(1'b1, 1'b1, 1'b0);
            void'(sb.pop_front());
        end
        for (int c = 0; c < 4; c++) begin
            tick(c < 2, 1'b0, 1'b0);
            e = sb.pop_front(); compared++;
            if (got24() !== e.a || got12() !== e.b) begin
                mismatched++;
                $display("FAIL key_race c=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", c, $time, got24(), got12(), e.a, e.b);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int c = 0; c < 24 && idx != 17; c++) begin
            tick(1'b1, 1'b1, 1'b0);
            void'(sb.pop_front());
        end
        for (int phase = 0; phase < 2; phase++) begin
            // phase 1 lands the reset on top of a live day_en pulse
            if (phase == 1) begin
                for (int c = 0; c < 24 && idx != 23; c++) begin
                    tick(1'b1, 1'b1, 1'b0);
                    void'(sb.pop_front());
                end
                tick(1'b1, 1'b1, 1'b0);
                void'(sb.pop_front());
            end
            #3 reset = 1'b1;
            model_reset();
            #1;
            e = sb.pop_front(); compared++;
            if (got24() !== e.a || got12() !== e.b) begin
                mismatched++;
                $display("FAIL reset_mid phase=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", phase, $time, got24(), got12(), e.a, e.b);
            end
            for (int c = 0; c < 6; c++) begin
                if (c == 4) reset = 1'b0;
                tick(1'b1, 1'b1, 1'b0);
                e = sb.pop_front(); compared++;
                if (got24() !== e.a || got12() !== e.b) begin
                    mismatched++;
                    $display("FAIL reset_release phase=%0d c=%0d t=%0t got24=%h got12=%h exp24=%h exp12=%h", phase, c, $time, got24(), got12(), e.a, e.b);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_run_24();
        test_set_mode();
        test_back_to_back();
        test_key_race();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
